// File: rtl/div8by4_seq.sv
// rtl/div8by4_seq.sv - sequential restoring 8/4 unsigned divider with valid/ready handshakes.
// Define DIV_RADIX4_EN for two restoring steps per cycle (4-cycle latency); default is radix-2 (8 cycles).
module div8by4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_zero
);

`ifdef DIV_RADIX4_EN
  localparam int CW = 2;
`else
  localparam int CW = 3;
`endif
  localparam logic [CW-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      dvd_q, dvd_d;
  logic [3:0]      dsr_q, dsr_d;
  logic [4:0]      rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      quo_q, quo_d;
  logic [3:0]      rmd_q, rmd_d;
  logic            dz_q, dz_d;
  logic [4:0]      rem_s;
  logic [7:0]      dvd_s;

  // One restoring step: the dividend register doubles as the quotient shift register.
  function automatic logic [12:0] div_step(input logic [4:0] rem,
                                           input logic [7:0] dvd,
                                           input logic [3:0] dsr);
    logic [4:0] sh;
    logic [5:0] diff;
    sh   = {rem[3:0], dvd[7]};
    diff = {1'b0, sh} - {2'b00, dsr};
    if (diff[5]) div_step = {sh, dvd[6:0], 1'b0};
    else         div_step = {diff[4:0], dvd[6:0], 1'b1};
  endfunction

`ifdef DIV_RADIX4_EN
  logic [4:0] rem_m;
  logic [7:0] dvd_m;
  always_comb begin
    {rem_m, dvd_m} = div_step(rem_q, dvd_q, dsr_q);
    {rem_s, dvd_s} = div_step(rem_m, dvd_m, dsr_q);
  end
`else
  always_comb begin
    {rem_s, dvd_s} = div_step(rem_q, dvd_q, dsr_q);
  end
`endif

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dsr_d   = divisor;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // A zero divisor spends its single RUN cycle here with the dividend still unshifted.
        if (dsr_q == 4'd0) begin
          quo_d   = 8'hFF;
          rmd_d   = dvd_q[3:0];
          dz_d    = 1'b1;
          state_d = DONE;
        end else begin
          rem_d = rem_s;
          dvd_d = dvd_s;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            quo_d   = dvd_s;
            rmd_d   = rem_s[3:0];
            dz_d    = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign div_zero  = dz_q;

endmodule
